// File: rtl/chatbot_soc_nios2_gen2_0_cpu_debug_mon_responder_pkg.sv
// Shared definitions for the debug monitor responder: FSM states and jdo field positions.
`timescale 1ns/1ps
package chatbot_soc_nios2_gen2_0_cpu_debug_mon_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } mon_state_e;

  localparam int JDO_RD_BIT     = 35;
  localparam int JDO_INC_BIT    = 34;
  localparam int JDO_CLRERR_BIT = 33;
  localparam int JDO_ADDR_LSB   = 17;
  localparam int JDO_WDATA_LSB  = 4;

  function automatic logic [31:0] jdo_wdata(input logic [37:0] jdo);
    return jdo[JDO_WDATA_LSB +: 32];
  endfunction

endpackage

// File: rtl/chatbot_soc_nios2_gen2_0_cpu_debug_mon_timeout.sv
// Clearable saturating cycle counter; tc flags that the increment now pending reaches LIMIT.
`timescale 1ns/1ps
module chatbot_soc_nios2_gen2_0_cpu_debug_mon_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_r;

  // Count cycles spent waiting; clear has priority, value holds once LIMIT is reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (en && (count_r != W'(LIMIT))) begin
      count_r <= count_r + W'(1);
    end
  end

  assign tc = (count_r == W'(LIMIT - 1));

endmodule

// File: rtl/chatbot_soc_nios2_gen2_0_cpu_debug_mon_responder.sv
// Executes debug-slave monitor reads/writes against the monitor RAM and reports MonDReg/ready/error.
`timescale 1ns/1ps
module chatbot_soc_nios2_gen2_0_cpu_debug_mon_responder
  import chatbot_soc_nios2_gen2_0_cpu_debug_mon_responder_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int TIMEOUT  = 255,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  mon_state_e        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic              inc_en_r;
  logic              cnt_clear_s;
  logic              cnt_en_s;
  logic              cnt_tc_s;
  logic              any_strobe_s;
  logic [ADDR_W-1:0] jdo_addr_s;
  logic [31:0]       jdo_wdata_s;
  logic              unused_jdo_s;

  assign jdo_addr_s   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_wdata_s  = jdo_wdata(jdo);
  assign any_strobe_s = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign unused_jdo_s = ^{jdo[37:36], jdo[3:0]};

  // Timeout counter control: cleared while idle and on the grant that enters WAIT_RD.
  always_comb begin
    cnt_clear_s = 1'b0;
    cnt_en_s    = 1'b0;
    case (state_r)
      IDLE:    cnt_clear_s = 1'b1;
      REQ: begin
        if (mem_gnt) begin
          cnt_clear_s = 1'b1;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      WAIT_RD: cnt_en_s = 1'b1;
      default: cnt_clear_s = 1'b0;
    endcase
  end

  chatbot_soc_nios2_gen2_0_cpu_debug_mon_timeout #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear_s),
    .en     (cnt_en_s),
    .tc     (cnt_tc_s)
  );

  // Command decode, memory handshake and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      addr_r        <= {ADDR_W{1'b0}};
      inc_en_r      <= AUTO_INC;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= {ADDR_W{1'b0}};
      mem_wdata     <= 32'h0000_0000;
      MonDReg       <= 32'h0000_0000;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_action_ocimem_b) begin
            mem_req       <= 1'b1;
            mem_we        <= 1'b1;
            mem_addr      <= addr_r;
            mem_wdata     <= jdo_wdata_s;
            MonDReg       <= jdo_wdata_s;
            monitor_ready <= 1'b0;
            state_r       <= REQ;
            if (take_action_ocimem_a || take_no_action_ocimem_a) begin
              monitor_error <= 1'b1;
            end
          end else if (take_action_ocimem_a) begin
            addr_r   <= jdo_addr_s;
            inc_en_r <= jdo[JDO_INC_BIT];
            // A dropped coincident strobe outranks the clear request.
            if (take_no_action_ocimem_a) begin
              monitor_error <= 1'b1;
            end else if (jdo[JDO_CLRERR_BIT]) begin
              monitor_error <= 1'b0;
            end
            if (jdo[JDO_RD_BIT]) begin
              mem_req       <= 1'b1;
              mem_we        <= 1'b0;
              mem_addr      <= jdo_addr_s;
              monitor_ready <= 1'b0;
              state_r       <= REQ;
            end
          end else if (take_no_action_ocimem_a && jdo[JDO_RD_BIT]) begin
            mem_req       <= 1'b1;
            mem_we        <= 1'b0;
            mem_addr      <= addr_r;
            monitor_ready <= 1'b0;
            state_r       <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state_r <= mem_we ? DONE : WAIT_RD;
          end else if (cnt_tc_s) begin
            mem_req       <= 1'b0;
            monitor_error <= 1'b1;
            monitor_ready <= 1'b1;
            state_r       <= IDLE;
          end
        end
        WAIT_RD: begin
          if (mem_rvalid) begin
            MonDReg <= mem_rdata;
            state_r <= DONE;
          end else if (cnt_tc_s) begin
            monitor_error <= 1'b1;
            monitor_ready <= 1'b1;
            state_r       <= IDLE;
          end
        end
        DONE: begin
          if (inc_en_r) begin
            addr_r <= addr_r + ADDR_W'(1);
          end
          monitor_ready <= 1'b1;
          state_r       <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
      if ((state_r != IDLE) && any_strobe_s) begin
        monitor_error <= 1'b1;
      end
    end
  end

endmodule
